// File: rtl/boot_loader_pkg.sv
// Shared types and defaults for the I-MEM boot loader.
// The states cover the frame: header, data words, trailing checksum.
package boot_loader_pkg;

   localparam int         BOOT_BITS      = 32;
   localparam int         BOOT_ADDRIW    = 11;
   localparam logic [7:0] BOOT_SYNC_BYTE = 8'hA5;
   localparam int         BOOT_LEN_W     = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_DATA,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } boot_state_t;

endpackage

// File: rtl/boot_word_asm.sv
// Assembles little-endian bytes into words and keeps a running mod-256 checksum.
// word_out changes only when a word completes, so it stays stable until the next write.
module boot_word_asm #(
   parameter int BITS = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [7:0]      byte_in,
   input  logic            valid,
   input  logic            clr,
   output logic            lane_last,
   output logic [BITS-1:0] word_out,
   output logic            word_rdy,
   output logic [7:0]      csum
);

   localparam int LANES = BITS / 8;
   localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

   logic [LW-1:0]   lane_q, lane_d;
   logic [BITS-1:0] acc_q, acc_d;
   logic [BITS-1:0] word_q, word_d;
   logic            rdy_q, rdy_d;
   logic [7:0]      csum_q, csum_d;

   assign lane_last = valid && (lane_q == LW'(LANES - 1));

   // NOTE: every variable gets its default first, so no path through this block can infer a latch.
   always_comb begin
      lane_d = lane_q;
      acc_d  = acc_q;
      word_d = word_q;
      rdy_d  = 1'b0;
      csum_d = csum_q;
      if (clr) begin
         lane_d = '0;
         csum_d = '0;
      end else if (valid) begin
         acc_d[8*lane_q +: 8] = byte_in;
         csum_d = csum_q + byte_in;
         if (lane_last) begin
            lane_d = '0;
            word_d = acc_d;
            rdy_d  = 1'b1;
         end else begin
            lane_d = lane_q + 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments; reset is synchronous to match the SoC.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lane_q <= '0;
         acc_q  <= '0;
         word_q <= '0;
         rdy_q  <= 1'b0;
         csum_q <= '0;
      end else begin
         lane_q <= lane_d;
         acc_q  <= acc_d;
         word_q <= word_d;
         rdy_q  <= rdy_d;
         csum_q <= csum_d;
      end
   end

   assign word_out = word_q;
   assign word_rdy = rdy_q;
   assign csum     = csum_q;

endmodule

// File: rtl/boot_loader.sv
// Frames the UART byte stream into I-MEM writes and holds the CPU until the checksum passes.
// The FSM, word index and inter-byte timeout live here; byte packing is in boot_word_asm.
module boot_loader
   import boot_loader_pkg::*;
#(
   parameter int         BITS        = BOOT_BITS,
   parameter int         ADDRIW      = BOOT_ADDRIW,
   parameter logic [7:0] SYNC_BYTE   = BOOT_SYNC_BYTE,
   parameter int         TIMEOUT_CYC = 50_000_000,
   parameter bit         AUTO_START  = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              bootloading,
   output logic              we_boot,
   output logic [ADDRIW-1:0] wdata_addr,
   output logic [BITS-1:0]   wdata_data,
   output logic              boot_done,
   output logic              boot_err
);

   localparam int TW      = $clog2(TIMEOUT_CYC + 1);
   localparam int LEN_MAX = 2 ** ADDRIW;

   boot_state_t             state_q, state_d;
   logic [BOOT_LEN_W-1:0]   len_q, len_d;
   logic [ADDRIW:0]         idx_q, idx_d;
   logic [ADDRIW-1:0]       addr_q, addr_d;
   logic [TW-1:0]           tmo_q, tmo_d;
   logic                    loading_q, loading_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;
   logic                    asm_valid, lane_last;
   logic [7:0]              csum;

   assign asm_valid = rx_valid && (state_q == ST_DATA);

   boot_word_asm #(.BITS(BITS)) u_asm (
      .clk       (clk),
      .rst_n     (rst_n),
      .byte_in   (rx_data),
      .valid     (asm_valid),
      .clr       (state_q == ST_SYNC),
      .lane_last (lane_last),
      .word_out  (wdata_data),
      .word_rdy  (we_boot),
      .csum      (csum)
   );

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      idx_d     = idx_q;
      addr_d    = addr_q;
      tmo_d     = '0;
      loading_d = loading_q;
      done_d    = done_q;
      err_d     = err_q;

      unique case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               state_d   = ST_SYNC;
               loading_d = 1'b1;
               done_d    = 1'b0;
               err_d     = 1'b0;
               idx_d     = '0;
            end
         end
         ST_SYNC: begin
            if (rx_valid && rx_data == SYNC_BYTE) state_d = ST_LEN_LO;
         end
         ST_LEN_LO: begin
            if (rx_valid) begin
               len_d[7:0] = rx_data;
               state_d    = ST_LEN_HI;
            end
         end
         ST_LEN_HI: begin
            if (rx_valid) begin
               len_d[15:8] = rx_data;
               if (len_d == '0) begin
                  state_d = ST_CSUM;
               end else if (len_d > BOOT_LEN_W'(LEN_MAX)) begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            // The address is captured with the 4th byte so it lines up with the write strobe.
            if (lane_last) begin
               addr_d = idx_q[ADDRIW-1:0];
               idx_d  = idx_q + 1'b1;
               if (BOOT_LEN_W'(idx_d) == len_q) state_d = ST_CSUM;
            end
         end
         ST_CSUM: begin
            if (rx_valid) begin
               if (rx_data == csum) begin
                  state_d   = ST_DONE;
                  loading_d = 1'b0;
                  done_d    = 1'b1;
               end else begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Idle gap inside a frame: count cycles without a byte, abort on reaching the limit.
      if (!rx_valid && (state_q inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM})) begin
         tmo_d = tmo_q + 1'b1;
         if (tmo_d == TW'(TIMEOUT_CYC)) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= AUTO_START ? ST_SYNC : ST_IDLE;
         len_q     <= '0;
         idx_q     <= '0;
         addr_q    <= '0;
         tmo_q     <= '0;
         loading_q <= AUTO_START;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         addr_q    <= addr_d;
         tmo_q     <= tmo_d;
         loading_q <= loading_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign bootloading = loading_q;
   assign wdata_addr  = addr_q;
   assign boot_done   = done_q;
   assign boot_err    = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: directed frame table, hand-written corner sequences,
// and random frames checked against a frame-parsing reference model.
module tb_boot_loader;

   localparam int         ADDRIW = 11;
   localparam int         BITS   = 32;
   localparam logic [7:0] SYNC   = 8'hA5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              bootloading;
   logic              we_boot;
   logic [ADDRIW-1:0] wdata_addr;
   logic [BITS-1:0]   wdata_data;
   logic              boot_done;
   logic              boot_err;

   int n_tests = 0;
   int n_fail  = 0;

   logic [ADDRIW-1:0] got_a[$];
   logic [BITS-1:0]   got_d[$];
   logic [ADDRIW-1:0] exp_a[$];
   logic [BITS-1:0]   exp_d[$];
   bit                exp_done;
   bit                exp_err;

   boot_loader #(
      .BITS        (BITS),
      .ADDRIW      (ADDRIW),
      .SYNC_BYTE   (SYNC),
      .TIMEOUT_CYC (100),
      .AUTO_START  (1'b1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .bootloading (bootloading),
      .we_boot     (we_boot),
      .wdata_addr  (wdata_addr),
      .wdata_data  (wdata_data),
      .boot_done   (boot_done),
      .boot_err    (boot_err)
   );

   always #5 clk = ~clk;

   // Write monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (we_boot === 1'b1) begin
         got_a.push_back(wdata_addr);
         got_d.push_back(wdata_data);
      end
   end

   initial begin
      #(10 * 95000);
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // Tasks start and end on a falling edge; each byte occupies exactly one cycle.
   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      rx_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic clear_got();
      got_a.delete();
      got_d.delete();
   endtask

   task automatic set_exp_normal();
      exp_a.delete();
      exp_d.delete();
      exp_a.push_back(11'd0);
      exp_d.push_back(32'h0000_0013);
      exp_a.push_back(11'd1);
      exp_d.push_back(32'h0010_0093);
   endtask

   task automatic send_normal_body();
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
   endtask

   task automatic cmp_writes(input string tag);
      check($sformatf("%s nwr", tag), 64'(got_a.size()), 64'(exp_a.size()));
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
         check($sformatf("%s addr[%0d]", tag, i), 64'(got_a[i]), 64'(exp_a[i]));
         check($sformatf("%s data[%0d]", tag, i), 64'(got_d[i]), 64'(exp_d[i]));
      end
   endtask

   task automatic cmp_flags(input string tag, input bit done, input bit err);
      check($sformatf("%s boot_done", tag), 64'(boot_done), 64'(done));
      check($sformatf("%s boot_err", tag), 64'(boot_err), 64'(err));
      check($sformatf("%s bootloading", tag), 64'(bootloading), 64'(!done));
   endtask

   // Reference model: parse a complete byte stream as seen from the SYNC state.
   task automatic model(input logic [7:0] s[$]);
      int         p;
      int         len;
      logic [7:0] sum;
      exp_a.delete();
      exp_d.delete();
      exp_done = 1'b0;
      exp_err  = 1'b0;
      p = 0;
      while (p < s.size() && s[p] != SYNC) p++;
      if (p + 2 >= s.size()) return;
      len = int'(s[p+1]) + 256 * int'(s[p+2]);
      p   = p + 3;
      if (len > (1 << ADDRIW)) begin
         exp_err = 1'b1;
         return;
      end
      sum = 8'h00;
      for (int k = 0; k < len; k++) begin
         exp_a.push_back(ADDRIW'(k));
         exp_d.push_back({s[p+3], s[p+2], s[p+1], s[p]});
         sum = sum + s[p] + s[p+1] + s[p+2] + s[p+3];
         p   = p + 4;
      end
      if (p < s.size()) begin
         if (s[p] == sum) exp_done = 1'b1;
         else             exp_err  = 1'b1;
      end
   endtask

   task automatic run_stream(input logic [7:0] s[$], input int max_gap);
      clear_got();
      foreach (s[i]) begin
         if (max_gap > 0) idle($urandom_range(0, max_gap));
         send_byte(s[i]);
      end
      idle(4);
   endtask

   typedef struct {
      logic [0:15][7:0] b;
      int               n;
      bit               done;
      bit               err;
      int               nwr;
      logic [31:0]      w0;
      logic [31:0]      w1;
   } vec_t;

   vec_t tbl[6];

   initial begin
      logic [7:0] s[$];
      logic [7:0] b;
      logic [7:0] sum;
      int         len;

      tbl[0] = '{b: {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB6, 32'h0},
                 n: 12, done: 1'b1, err: 1'b0, nwr: 2, w0: 32'h0000_0013, w1: 32'h0010_0093};
      tbl[1] = '{b: {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB7, 32'h0},
                 n: 12, done: 1'b0, err: 1'b1, nwr: 2, w0: 32'h0000_0013, w1: 32'h0010_0093};
      tbl[2] = '{b: {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00,
                     8'h10, 8'h00, 8'hB6, 8'h00},
                 n: 15, done: 1'b1, err: 1'b0, nwr: 2, w0: 32'h0000_0013, w1: 32'h0010_0093};
      tbl[3] = '{b: {8'hA5, 8'h01, 8'h08, 104'h0},
                 n: 3, done: 1'b0, err: 1'b1, nwr: 0, w0: 32'h0, w1: 32'h0};
      tbl[4] = '{b: {8'hA5, 8'h00, 8'h00, 8'h00, 96'h0},
                 n: 4, done: 1'b1, err: 1'b0, nwr: 0, w0: 32'h0, w1: 32'h0};
      tbl[5] = '{b: {8'hA5, 8'h00, 8'h00, 8'h01, 96'h0},
                 n: 4, done: 1'b0, err: 1'b1, nwr: 0, w0: 32'h0, w1: 32'h0};

      rst_n    = 1'b0;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(negedge clk);

      check("reset bootloading", 64'(bootloading), 64'd1);
      check("reset boot_done", 64'(boot_done), 64'd0);
      check("reset boot_err", 64'(boot_err), 64'd0);
      check("reset we_boot", 64'(we_boot), 64'd0);
      check("reset wdata_addr", 64'(wdata_addr), 64'd0);
      check("reset wdata_data", 64'(wdata_data), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed frame table; a start pulse in SYNC is harmless, after DONE/ERR it restarts.
      for (int t = 0; t < 6; t++) begin
         pulse_start();
         check($sformatf("vec%0d restart bootloading", t), 64'(bootloading), 64'd1);
         exp_a.delete();
         exp_d.delete();
         if (tbl[t].nwr > 0) begin exp_a.push_back(11'd0); exp_d.push_back(tbl[t].w0); end
         if (tbl[t].nwr > 1) begin exp_a.push_back(11'd1); exp_d.push_back(tbl[t].w1); end
         clear_got();
         for (int i = 0; i < tbl[t].n; i++) send_byte(tbl[t].b[i]);
         idle(4);
         cmp_writes($sformatf("vec%0d", t));
         cmp_flags($sformatf("vec%0d", t), tbl[t].done, tbl[t].err);
      end

      // Inter-byte timeout inside DATA, then recovery with a valid frame.
      pulse_start();
      clear_got();
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h13);
      idle(99);
      check("timeout err before limit", 64'(boot_err), 64'd0);
      idle(1);
      check("timeout err at limit", 64'(boot_err), 64'd1);
      check("timeout bootloading", 64'(bootloading), 64'd1);
      check("timeout no write", 64'(got_a.size()), 64'd0);
      pulse_start();
      clear_got();
      set_exp_normal();
      send_normal_body();
      send_byte(8'hB6);
      idle(4);
      cmp_writes("after timeout");
      cmp_flags("after timeout", 1'b1, 1'b0);
      check("hold wdata_addr", 64'(wdata_addr), 64'd1);
      check("hold wdata_data", 64'(wdata_data), 64'h0010_0093);

      // Reset after two data bytes abandons the frame.
      pulse_start();
      clear_got();
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h13); send_byte(8'h00);
      rst_n = 1'b0;
      idle(2);
      check("midrst bootloading", 64'(bootloading), 64'd1);
      check("midrst boot_done", 64'(boot_done), 64'd0);
      check("midrst boot_err", 64'(boot_err), 64'd0);
      check("midrst we_boot", 64'(we_boot), 64'd0);
      check("midrst wdata_addr", 64'(wdata_addr), 64'd0);
      check("midrst wdata_data", 64'(wdata_data), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      clear_got();
      set_exp_normal();
      send_normal_body();
      send_byte(8'hB6);
      idle(4);
      cmp_writes("after midrst");
      cmp_flags("after midrst", 1'b1, 1'b0);

      // start during DATA is ignored.
      pulse_start();
      clear_got();
      set_exp_normal();
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h13);
      pulse_start();
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
      send_byte(8'hB6);
      idle(4);
      cmp_writes("start mid-frame");
      cmp_flags("start mid-frame", 1'b1, 1'b0);

      // start coincident with the checksum byte: the frame completes, start is dropped.
      pulse_start();
      clear_got();
      set_exp_normal();
      send_normal_body();
      start = 1'b1;
      send_byte(8'hB6);
      start = 1'b0;
      idle(4);
      cmp_writes("start with csum");
      cmp_flags("start with csum", 1'b1, 1'b0);

      // Random frames against the reference model.
      for (int r = 0; r < 25; r++) begin
         s.delete();
         for (int g = $urandom_range(0, 3); g > 0; g--) begin
            do b = 8'($urandom_range(0, 255)); while (b == SYNC);
            s.push_back(b);
         end
         len = $urandom_range(0, 5);
         s.push_back(SYNC);
         s.push_back(8'(len));
         s.push_back(8'h00);
         sum = 8'h00;
         for (int i = 0; i < 4 * len; i++) begin
            b = 8'($urandom_range(0, 255));
            s.push_back(b);
            sum = sum + b;
         end
         if ($urandom_range(0, 3) == 0) sum = sum + 8'($urandom_range(1, 255));
         s.push_back(sum);
         pulse_start();
         model(s);
         run_stream(s, (r % 2 == 0) ? 0 : 5);
         cmp_writes($sformatf("rand%0d", r));
         cmp_flags($sformatf("rand%0d", r), exp_done, exp_err);
      end

      // Largest legal frame: len == 2^ADDRIW, last address all-ones.
      s.delete();
      s.push_back(SYNC);
      s.push_back(8'h00);
      s.push_back(8'h08);
      sum = 8'h00;
      for (int i = 0; i < 4 * (1 << ADDRIW); i++) begin
         b = 8'($urandom_range(0, 255));
         s.push_back(b);
         sum = sum + b;
      end
      s.push_back(sum);
      pulse_start();
      model(s);
      run_stream(s, 0);
      cmp_writes("maxlen");
      cmp_flags("maxlen", 1'b1, 1'b0);
      check("maxlen last addr", 64'(wdata_addr), 64'h7FF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Writer side of the I-MEM boot port. Consumes a byte stream from the UART receiver and frames it as header, little-endian 32-bit words, and checksum.
- Writes each word into I-MEM through the we_boot / wdata_addr / wdata_data port.
- Holds bootloading high while the load is in progress, so the fetch stage and PC stay frozen. Releases the CPU only after the checksum passes.
- Sits between uart_rx and the I-MEM boot port at SoC top level.

Parameters:
- BITS, 32 (from common_params): instruction/data width.
- ADDRIW, 11 (from common_params): I-MEM word-address width; capacity 2^ADDRIW words.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYC, 50_000_000: idle cycles allowed between bytes inside a frame before abort.
- AUTO_START, 1: when 1, enter load mode directly out of reset.

Ports:
- clk  input  1  global clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  single-cycle pulse requesting a (re)load
- rx_data  input  8  received byte
- rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle
- bootloading  output  1  high while loading or in error; holds the CPU
- we_boot  output  1  one-cycle I-MEM write strobe
- wdata_addr  output  ADDRIW  I-MEM word address
- wdata_data  output  BITS  I-MEM write data
- boot_done  output  1  sticky: last load succeeded
- boot_err  output  1  sticky: last load failed

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk.
  - State goes to SYNC if AUTO_START=1, else IDLE.
  - bootloading = AUTO_START. we_boot=0, wdata_addr=0, wdata_data=0, boot_done=0, boot_err=0.
  - All counters and the checksum are cleared.
  - Reset mid-load abandons the frame; words already written stay in I-MEM.
- Frame format, in byte order: SYNC_BYTE, LEN_LO, LEN_HI, then LEN words of 4 bytes each (LSB first), then CSUM.
  - CSUM = 8-bit modulo-256 sum of all data bytes only (header excluded).
- States: IDLE, SYNC, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
- Transitions:
  - IDLE / DONE / ERR: start -> SYNC. On entry, bootloading=1, boot_done=0, boot_err=0, word index = 0, checksum = 0.
  - SYNC: rx_valid && rx_data==SYNC_BYTE -> LEN_LO. Any other byte is ignored, and the timeout does not run.
  - LEN_LO: byte is latched into len[7:0] -> LEN_HI.
  - LEN_HI: byte is latched into len[15:8].
    - len==0 -> CSUM.
    - len > 2^ADDRIW -> ERR.
    - Otherwise -> DATA.
  - DATA: a 2-bit byte counter places each byte in lane [8k+7:8k]; checksum += byte.
    - On the 4th byte, the next cycle drives we_boot=1 for exactly 1 cycle, with wdata_addr = word index and wdata_data = the assembled word.
    - Word index increments after the write. After word len-1 is written -> CSUM.
  - CSUM: received byte == checksum -> DONE, else -> ERR.
  - DONE: bootloading=0, boot_done=1.
  - ERR: bootloading stays 1 (CPU held), boot_err=1.
- Write latency: 1 cycle from the 4th rx_valid to the we_boot pulse. wdata_addr and wdata_data hold their values until the next write.
- Timeout:
  - In LEN_LO, LEN_HI, DATA and CSUM, a counter increments on each cycle without rx_valid and clears on rx_valid.
  - Reaching TIMEOUT_CYC -> ERR.
- start while in SYNC through CSUM: ignored (no restart mid-frame).
- start in the same cycle as the byte that completes a frame: the frame completes; start is dropped.
- Back-to-back rx_valid on every cycle must be handled. The byte path accepts every cycle and has no backpressure.
- Word index width is ADDRIW+1, so len == 2^ADDRIW is legal and the last address is all-ones.

Decomposition:
- Into common_params: boot_state_t enum, SYNC_BYTE, BOOT_LEN_W=16.
- Sub-module boot_word_asm: byte-lane assembler plus running checksum, with byte_in, valid, clr, word_out, word_rdy, csum. The FSM, index and timeout stay in boot_loader.

Test Plan:
- Normal load: reset (AUTO_START=1), send A5 02 00 13 00 00 00 93 00 10 00 + CSUM 0xB6.
  - Required: we_boot pulses at addr 0 with 0x00000013 and addr 1 with 0x00100093.
  - Then boot_done=1 and bootloading=0.
- Bad checksum: same frame with CSUM 0xB7.
  - Required: both writes occur, then boot_err=1, bootloading stays 1, boot_done=0.
- Leading garbage: send 00 FF 5A, then the normal frame.
  - Required: garbage ignored; identical writes and DONE.
- Oversize length: A5 01 08 (len=2049, ADDRIW=11).
  - Required: ERR immediately, no we_boot.
- Timeout: A5 01 00 13, then idle TIMEOUT_CYC cycles (bench overrides it to 100).
  - Required: ERR at cycle 100, no we_boot.
  - Then a start pulse plus a valid frame -> DONE.
- Reset mid-frame: assert rst_n=0 after 2 data bytes, then release.
  - Required: all outputs at reset values; next full frame writes from addr 0.
